// File: rtl/axi4l_mem_initiator_if.sv
// Bundles the native PicoRV32-style memory port and the AXI4-lite initiator bus.
// The master modport is the initiator's view; slave is the requester plus responder view.
interface axi4l_mem_initiator_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        mem_axi_awvalid;
  logic        mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid;
  logic        mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid;
  logic        mem_axi_bready;
  logic        mem_axi_arvalid;
  logic        mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid;
  logic        mem_axi_rready;
  logic [31:0] mem_axi_rdata;

  modport master (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    input  mem_axi_awready,
    output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    input  mem_axi_wready,
    input  mem_axi_bvalid,
    output mem_axi_bready,
    output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    input  mem_axi_arready,
    input  mem_axi_rvalid, mem_axi_rdata,
    output mem_axi_rready
  );

  modport slave (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    output mem_axi_awready,
    input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    output mem_axi_wready,
    output mem_axi_bvalid,
    input  mem_axi_bready,
    input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    output mem_axi_arready,
    output mem_axi_rvalid, mem_axi_rdata,
    input  mem_axi_rready
  );
endinterface

// File: rtl/axi4l_mem_initiator.sv
// Native valid/ready memory port to single-outstanding AXI4-lite initiator, with an
// optional stall watchdog that aborts a transaction against a hung responder.
module axi4l_mem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         resetn,
  axi4l_mem_initiator_if.master        bus,
  output logic                         err_timeout
);
  localparam int unsigned   WDW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [WDW-1:0] WD_MAX  = {WDW{1'b1}};
  localparam bit             WD_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic           arvalid_q, arvalid_d;
  logic [31:0]    araddr_q, araddr_d;
  logic [2:0]     arprot_q, arprot_d;
  logic           rready_q, rready_d;
  logic           awvalid_q, awvalid_d;
  logic [31:0]    awaddr_q, awaddr_d;
  logic           wvalid_q, wvalid_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [3:0]     wstrb_q, wstrb_d;
  logic           bready_q, bready_d;
  logic           mem_ready_q, mem_ready_d;
  logic [31:0]    mem_rdata_q, mem_rdata_d;
  logic           err_q, err_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           busy_s;
  logic           hs_s;

  // Next-state, registered-output and watchdog logic.
  always_comb begin
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arprot_d    = arprot_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    awaddr_d    = awaddr_q;
    wvalid_d    = wvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bready_d    = bready_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    err_d       = err_q;
    wdog_d      = wdog_q;
    busy_s      = 1'b0;
    hs_s        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mem_valid) begin
          if (bus.mem_wstrb == 4'b0000) begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = bus.mem_addr;
            arprot_d  = {bus.mem_instr, 2'b00};
          end else begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = bus.mem_addr;
            wdata_d   = bus.mem_wdata;
            wstrb_d   = bus.mem_wstrb;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        busy_s = 1'b1;
        if (arvalid_q && bus.mem_axi_arready) begin
          hs_s      = 1'b1;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_DATA: begin
        busy_s = 1'b1;
        if (rready_q && bus.mem_axi_rvalid) begin
          hs_s        = 1'b1;
          rready_d    = 1'b0;
          mem_rdata_d = bus.mem_axi_rdata;
          mem_ready_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = RD_DATA;
        end
      end
      WR_REQ: begin
        busy_s = 1'b1;
        // AW and W retire independently; B is only accepted once both have gone.
        if (awvalid_q && bus.mem_axi_awready) begin
          hs_s      = 1'b1;
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (wvalid_q && bus.mem_axi_wready) begin
          hs_s     = 1'b1;
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end else begin
          state_d = WR_REQ;
        end
      end
      WR_RESP: begin
        busy_s = 1'b1;
        if (bready_q && bus.mem_axi_bvalid) begin
          hs_s        = 1'b1;
          bready_d    = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = WR_RESP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase

    // The abort deliberately breaks valid stability; it only fires on a dead responder.
    if (!busy_s || hs_s) begin
      wdog_d = {WDW{1'b0}};
    end else if (WD_EN && (wdog_q == WD_LAST)) begin
      wdog_d      = {WDW{1'b0}};
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      err_d       = 1'b1;
      mem_ready_d = 1'b1;
      state_d     = DONE;
      if ((state_q == RD_ADDR) || (state_q == RD_DATA)) begin
        mem_rdata_d = ERR_RDATA;
      end else begin
        mem_rdata_d = mem_rdata_q;
      end
    end else if (wdog_q != WD_MAX) begin
      wdog_d = wdog_q + WDW'(1'b1);
    end else begin
      wdog_d = wdog_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      arvalid_q   <= 1'b0;
      araddr_q    <= 32'h0000_0000;
      arprot_q    <= 3'b000;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= 32'h0000_0000;
      wvalid_q    <= 1'b0;
      wdata_q     <= 32'h0000_0000;
      wstrb_q     <= 4'b0000;
      bready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0000_0000;
      err_q       <= 1'b0;
      wdog_q      <= {WDW{1'b0}};
    end else begin
      state_q     <= state_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arprot_q    <= arprot_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      awaddr_q    <= awaddr_d;
      wvalid_q    <= wvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bready_q    <= bready_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      err_q       <= err_d;
      wdog_q      <= wdog_d;
    end
  end

  assign bus.mem_ready       = mem_ready_q;
  assign bus.mem_rdata       = mem_rdata_q;
  assign bus.mem_axi_arvalid = arvalid_q;
  assign bus.mem_axi_araddr  = araddr_q;
  assign bus.mem_axi_arprot  = arprot_q;
  assign bus.mem_axi_rready  = rready_q;
  assign bus.mem_axi_awvalid = awvalid_q;
  assign bus.mem_axi_awaddr  = awaddr_q;
  assign bus.mem_axi_awprot  = 3'b000;
  assign bus.mem_axi_wvalid  = wvalid_q;
  assign bus.mem_axi_wdata   = wdata_q;
  assign bus.mem_axi_wstrb   = wstrb_q;
  assign bus.mem_axi_bready  = bready_q;
  assign err_timeout         = err_q;
endmodule

// File: tb/tb_axi4l_mem_initiator.sv
// Self-checking bench: per-scenario tasks drive requester and responder, expected
// completions are queued at request time and popped when mem_ready pulses.
module tb_axi4l_mem_initiator;
  localparam int unsigned TO      = 8;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic resetn;
  logic err_timeout;
  axi4l_mem_initiator_if bus();

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_rd;
  logic        err_model;

  axi4l_mem_initiator #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR_VAL)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_drives();
    bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0; bus.mem_axi_awready = 1'b0; bus.mem_axi_wready = 1'b0;
    bus.mem_axi_bvalid = 1'b0; bus.mem_axi_arready = 1'b0; bus.mem_axi_rvalid = 1'b0;
    bus.mem_axi_rdata = 32'h0;
  endtask

  task automatic test_reset();
    logic [150:0] got;
    got = {bus.mem_ready, bus.mem_rdata, bus.mem_axi_awvalid, bus.mem_axi_awaddr, bus.mem_axi_awprot,
           bus.mem_axi_wvalid, bus.mem_axi_wdata, bus.mem_axi_wstrb, bus.mem_axi_bready,
           bus.mem_axi_arvalid, bus.mem_axi_araddr[31:0], bus.mem_axi_arprot, bus.mem_axi_rready,
           err_timeout};
    checks++;
    if (got !== 151'h0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", got);
    end
  endtask

  // A read: the responder raises arready after ar_wait arvalid cycles, rvalid r_wait cycles after AR.
  task automatic run_read(input string tag, input logic [31:0] addr, input logic instr,
                          input logic [31:0] data, input int ar_wait, input int r_wait,
                          input bit early_r, input int exp_lat);
    int   cyc = 0, arv = 0, ar_hs = 0;
    bit   ar_done = 0, r_done = 0, done = 0, abort;
    exp_t e;
    abort = (ar_wait >= int'(TO));
    if (abort) err_model = 1'b1;
    e.rdata = abort ? ERR_VAL : data;
    e.err   = err_model;
    last_rd = e.rdata;
    sb_q.push_back(e);
    bus.mem_valid = 1'b1; bus.mem_addr = addr; bus.mem_instr = instr; bus.mem_wstrb = 4'h0;
    while (!done && cyc < 100) begin
      @(negedge clk); cyc++;
      if (cyc == 2) begin
        bus.mem_addr = ~addr; bus.mem_instr = ~instr; bus.mem_wstrb = 4'hF;
      end
      checks++;
      if (bus.mem_axi_rready && !ar_done) begin
        errors++; $display("FAIL %s rready_before_ar: got 1 want 0 (cycle %0d)", tag, cyc);
      end
      if (bus.mem_axi_arvalid) begin
        arv++; checks++;
        if ({bus.mem_axi_araddr, bus.mem_axi_arprot} !== {addr, instr, 2'b00}) begin
          errors++; $display("FAIL %s ar_payload: got %h/%b want %h/%b", tag, bus.mem_axi_araddr,
                             bus.mem_axi_arprot, addr, {instr, 2'b00});
        end
      end
      if (bus.mem_ready) begin
        done = 1; e = sb_q.pop_front(); bus.mem_valid = 1'b0;
        checks++;
        if (bus.mem_rdata !== e.rdata) begin
          errors++; $display("FAIL %s rdata: got %h want %h", tag, bus.mem_rdata, e.rdata);
        end
        checks++;
        if (err_timeout !== e.err) begin
          errors++; $display("FAIL %s err_timeout: got %b want %b", tag, err_timeout, e.err);
        end
        if (exp_lat > 0) begin
          checks++;
          if (cyc != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, exp_lat);
          end
        end
      end
      bus.mem_axi_arready = bus.mem_axi_arvalid && (arv > ar_wait);
      bus.mem_axi_rvalid  = !r_done && (early_r || (ar_done && (cyc - ar_hs >= r_wait)));
      bus.mem_axi_rdata   = data;
      if (bus.mem_axi_arvalid && bus.mem_axi_arready) begin ar_done = 1; ar_hs = cyc; end
      if (bus.mem_axi_rvalid && bus.mem_axi_rready) r_done = 1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s no_mem_ready: got none want pulse within 100 cycles", tag);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    checks++;
    if (arv != (abort ? int'(TO) : ar_wait + 1)) begin
      errors++; $display("FAIL %s arvalid_cycles: got %0d want %0d", tag, arv, abort ? int'(TO) : ar_wait + 1);
    end
    idle_drives();
    @(negedge clk);
    checks++;
    if ({bus.mem_ready, bus.mem_axi_arvalid, bus.mem_axi_rready} !== 3'b000) begin
      errors++; $display("FAIL %s after_done: got %b want 000", tag,
                         {bus.mem_ready, bus.mem_axi_arvalid, bus.mem_axi_rready});
    end
  endtask

  // A write: AW and W ready after their own wait counts, bvalid b_wait cycles after both (or early).
  task automatic run_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_wait, input int w_wait,
                           input int b_wait, input bit early_b, input int exp_lat);
    int   cyc = 0, awv = 0, wv = 0, both_cyc = 0;
    bit   aw_done = 0, w_done = 0, b_done = 0, done = 0;
    exp_t e;
    e.rdata = last_rd;
    e.err   = err_model;
    sb_q.push_back(e);
    bus.mem_valid = 1'b1; bus.mem_addr = addr; bus.mem_wdata = data; bus.mem_wstrb = strb;
    while (!done && cyc < 100) begin
      @(negedge clk); cyc++;
      if (cyc == 2) begin
        bus.mem_addr = ~addr; bus.mem_wdata = ~data; bus.mem_wstrb = ~strb;
      end
      checks++;
      if (bus.mem_axi_bready && !(aw_done && w_done)) begin
        errors++; $display("FAIL %s bready_early: got 1 want 0 (cycle %0d)", tag, cyc);
      end
      if (bus.mem_axi_awvalid) begin
        awv++; checks++;
        if ({bus.mem_axi_awaddr, bus.mem_axi_awprot} !== {addr, 3'b000}) begin
          errors++; $display("FAIL %s aw_payload: got %h/%b want %h/000", tag, bus.mem_axi_awaddr,
                             bus.mem_axi_awprot, addr);
        end
      end
      if (bus.mem_axi_wvalid) begin
        wv++; checks++;
        if ({bus.mem_axi_wdata, bus.mem_axi_wstrb} !== {data, strb}) begin
          errors++; $display("FAIL %s w_payload: got %h/%b want %h/%b", tag, bus.mem_axi_wdata,
                             bus.mem_axi_wstrb, data, strb);
        end
      end
      if (bus.mem_ready) begin
        done = 1; e = sb_q.pop_front(); bus.mem_valid = 1'b0;
        checks++;
        if ({bus.mem_rdata, err_timeout} !== {e.rdata, e.err}) begin
          errors++; $display("FAIL %s rdata_err_held: got %h/%b want %h/%b", tag, bus.mem_rdata,
                             err_timeout, e.rdata, e.err);
        end
        if (exp_lat > 0) begin
          checks++;
          if (cyc != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, exp_lat);
          end
        end
      end
      bus.mem_axi_awready = bus.mem_axi_awvalid && (awv > aw_wait);
      bus.mem_axi_wready  = bus.mem_axi_wvalid && (wv > w_wait);
      bus.mem_axi_bvalid  = !b_done && (early_b || (aw_done && w_done && (cyc - both_cyc >= b_wait)));
      if (bus.mem_axi_awvalid && bus.mem_axi_awready) aw_done = 1;
      if (bus.mem_axi_wvalid && bus.mem_axi_wready) w_done = 1;
      if (bus.mem_axi_awvalid && bus.mem_axi_awready || bus.mem_axi_wvalid && bus.mem_axi_wready)
        both_cyc = cyc;
      if (bus.mem_axi_bvalid && bus.mem_axi_bready) b_done = 1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s no_mem_ready: got none want pulse within 100 cycles", tag);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    checks++;
    if (awv != aw_wait + 1 || wv != w_wait + 1) begin
      errors++; $display("FAIL %s valid_cycles: got aw=%0d w=%0d want aw=%0d w=%0d", tag, awv, wv,
                         aw_wait + 1, w_wait + 1);
    end
    idle_drives();
    @(negedge clk);
    checks++;
    if ({bus.mem_ready, bus.mem_axi_awvalid, bus.mem_axi_wvalid, bus.mem_axi_bready} !== 4'b0000) begin
      errors++; $display("FAIL %s after_done: got %b want 0000", tag,
                         {bus.mem_ready, bus.mem_axi_awvalid, bus.mem_axi_wvalid, bus.mem_axi_bready});
    end
  endtask

  task automatic test_read_basic();
    run_read("read_basic", 32'h0000_0100, 1'b0, 32'h1234_5678, 0, 2, 1'b0, 0);
    // Edges IDLE->RD_ADDR, RD_ADDR->RD_DATA, RD_DATA->DONE: mem_ready seen 3 negedges after request.
    run_read("read_min_lat", 32'h0000_0200, 1'b0, 32'hA5A5_0001, 0, 0, 1'b0, 3);
  endtask

  task automatic test_fetch();
    run_read("fetch", 32'h0000_0040, 1'b1, 32'hCAFE_F00D, 1, 0, 1'b0, 0);
    run_read("early_rvalid", 32'h0000_0044, 1'b0, 32'h0BAD_CAFE, 2, 0, 1'b1, 0);
  endtask

  task automatic test_write();
    run_write("write_w_first", 32'h1000_0000, 32'h0000_0041, 4'b0001, 3, 0, 1, 1'b0, 0);
    run_write("write_aw_first", 32'h1000_0004, 32'h5555_AAAA, 4'b1100, 0, 2, 0, 1'b0, 0);
    run_write("write_min_lat", 32'h1000_0008, 32'h7777_8888, 4'b1111, 0, 0, 0, 1'b1, 3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        run_read("b2b_read", 32'h2000_0000 + 32'(i * 4), 1'(i % 4 == 0), $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
      end else begin
        run_write("b2b_write", 32'h3000_0000 + 32'(i * 4), $urandom, 4'($urandom_range(1, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  1'($urandom_range(0, 1)), 0);
      end
    end
  endtask

  task automatic test_timeout();
    run_read("timeout_read", 32'h0000_0300, 1'b0, 32'h1111_2222, 1000, 0, 1'b0, 0);
    run_read("after_timeout", 32'h0000_0304, 1'b0, 32'h3333_4444, 0, 1, 1'b0, 0);
  endtask

  task automatic test_reset_mid_write();
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h4000_0000; bus.mem_wdata = 32'h9999_0000;
    bus.mem_wstrb = 4'b1111;
    @(negedge clk); @(negedge clk);
    checks++;
    if (bus.mem_axi_awvalid !== 1'b1) begin
      errors++; $display("FAIL reset_mid awvalid_before: got %b want 1", bus.mem_axi_awvalid);
    end
    resetn = 1'b0;
    #1;
    test_reset();
    idle_drives();
    last_rd = 32'h0; err_model = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    run_read("post_reset_read", 32'h0000_0008, 1'b0, 32'h0F0F_1234, 0, 0, 1'b0, 3);
  endtask

  initial begin
    resetn = 1'b0; last_rd = 32'h0; err_model = 1'b0;
    idle_drives();
    repeat (3) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    @(negedge clk);
    test_reset();
    test_read_basic();
    test_fetch();
    test_write();
    test_back_to_back();
    test_timeout();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
